// File: rtl/if_imem_responder.sv
// Instruction-memory responder on the memory side of the fetch interface.
// It returns one 32-bit word a fixed LATENCY cycles after it accepts a request, and it drops in-flight fetches on flush.
module if_imem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  input  logic                     flush,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_ins,
  output logic [31:0]              rsp_addr,
  output logic                     busy,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [31:0]    cap_ins;
  logic [31:0]    cap_addr;
  logic [31:0]    hold_ins;
  logic [31:0]    hold_addr;
  logic [31:0]    mem [DEPTH];

  logic [AW-1:0]  idx;
  logic           in_range;
  logic [31:0]    rd_word;
  logic           deliver;

  assign idx      = req_addr[AW+1:2];
  assign in_range = (req_addr >> (AW + 2)) == 32'd0;
  assign rd_word  = in_range ? mem[idx] : 32'h0000_0000;

  // A flush in the response cycle suppresses the pulse. The outputs then keep showing the last delivered word.
  assign deliver   = (state == RESP) && !flush;
  assign rsp_valid = deliver;
  assign rsp_ins   = deliver ? cap_ins  : hold_ins;
  assign rsp_addr  = deliver ? cap_addr : hold_addr;

  // The program-load port writes in every state. The array has no reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Fetch sequencing. The capture samples the array before a same-edge load lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      busy      <= 1'b0;
      cap_ins   <= 32'h0;
      cap_addr  <= 32'h0;
      hold_ins  <= 32'h0;
      hold_addr <= 32'h0;
    end else begin
      if (deliver) begin
        hold_ins  <= cap_ins;
        hold_addr <= cap_addr;
      end
      case (state)
        IDLE, RESP: begin
          if (req_valid) begin
            cap_ins  <= rd_word;
            cap_addr <= req_addr;
            if (LATENCY == 1) begin
              state <= RESP;
              busy  <= 1'b0;
            end else begin
              state <= WAIT;
              busy  <= 1'b1;
              count <= CW'(LATENCY - 2);
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WAIT: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (count == '0) begin
            state <= RESP;
            busy  <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_imem_responder.sv
// Directed bench for if_imem_responder.
// One instance is built with LATENCY=2 and a second instance with LATENCY=1. Each scenario has its own task with inline comparisons.
module tb_if_imem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid, flush, load_en;
  logic [31:0] req_addr, load_data;
  logic [7:0]  load_addr;
  logic        rsp_valid, busy;
  logic [31:0] rsp_ins, rsp_addr;

  logic        o_req_valid, o_flush, o_load_en;
  logic [31:0] o_req_addr, o_load_data;
  logic [7:0]  o_load_addr;
  logic        o_rsp_valid, o_busy;
  logic [31:0] o_rsp_ins, o_rsp_addr;

  int checks = 0;
  int failures = 0;
  logic [31:0] words [4];

  if_imem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ins(rsp_ins), .rsp_addr(rsp_addr), .busy(busy),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  if_imem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(o_req_valid), .req_addr(o_req_addr), .flush(o_flush),
    .rsp_valid(o_rsp_valid), .rsp_ins(o_rsp_ins), .rsp_addr(o_rsp_addr), .busy(o_busy),
    .load_en(o_load_en), .load_addr(o_load_addr), .load_data(o_load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (rsp_ins !== 32'h0) begin failures++; $display("FAIL reset_rsp_ins got=%08h exp=00000000", rsp_ins); end
    checks++; if (rsp_addr !== 32'h0) begin failures++; $display("FAIL reset_rsp_addr got=%08h exp=00000000", rsp_addr); end
    checks++; if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_l1_valid got=%0h exp=0", o_rsp_valid); end
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    tick();
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic test_single_fetch();
    tick();
    req_valid = 1'b1; req_addr = 32'h0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_t0 got=%0h exp=0", busy); end
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_t1 got=%0h exp=1", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_valid_t1 got=%0h exp=0", rsp_valid); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid_t2 got=%0h exp=1", rsp_valid); end
    checks++; if (rsp_ins !== 32'hE3A00001) begin failures++; $display("FAIL single_ins got=%08h exp=E3A00001", rsp_ins); end
    checks++; if (rsp_addr !== 32'h0) begin failures++; $display("FAIL single_addr got=%08h exp=00000000", rsp_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_t2 got=%0h exp=0", busy); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_valid_t3 got=%0h exp=0", rsp_valid); end
    checks++; if (rsp_ins !== 32'hE3A00001) begin failures++; $display("FAIL single_hold_ins got=%08h exp=E3A00001", rsp_ins); end
  endtask

  task automatic test_back_to_back();
    tick();
    req_valid = 1'b1; req_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy[%0d] got=%0h exp=1", i, busy); end
      tick();
      if (i < 3) req_addr = 32'(4 * (i + 1));
      else req_valid = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%0h exp=1", i, rsp_valid); end
      checks++; if (rsp_ins !== words[i]) begin failures++; $display("FAIL b2b_ins[%0d] got=%08h exp=%08h", i, rsp_ins, words[i]); end
      checks++; if (rsp_addr !== 32'(4 * i)) begin failures++; $display("FAIL b2b_addr[%0d] got=%08h exp=%08h", i, rsp_addr, 32'(4 * i)); end
    end
  endtask

  task automatic test_flush_wait();
    tick();
    req_valid = 1'b1; req_addr = 32'h4;
    tick();
    flush = 1'b1; req_addr = 32'hC;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL flushw_valid_t1 got=%0h exp=0", rsp_valid); end
    tick();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL flushw_valid_t2 got=%0h exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flushw_busy_t2 got=%0h exp=0", busy); end
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flushw_busy_t3 got=%0h exp=1", busy); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL flushw_valid_t4 got=%0h exp=1", rsp_valid); end
    checks++; if (rsp_ins !== 32'hEAFFFFFE) begin failures++; $display("FAIL flushw_ins got=%08h exp=EAFFFFFE", rsp_ins); end
    checks++; if (rsp_addr !== 32'hC) begin failures++; $display("FAIL flushw_addr got=%08h exp=0000000C", rsp_addr); end
  endtask

  task automatic test_flush_resp();
    tick();
    req_valid = 1'b1; req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL flushr_valid got=%0h exp=0", rsp_valid); end
    checks++; if (rsp_ins !== 32'hEAFFFFFE) begin failures++; $display("FAIL flushr_hold_ins got=%08h exp=EAFFFFFE", rsp_ins); end
    tick();
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flushr_busy got=%0h exp=1", busy); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL flushr_new_valid got=%0h exp=1", rsp_valid); end
    checks++; if (rsp_ins !== 32'hE3A01002) begin failures++; $display("FAIL flushr_new_ins got=%08h exp=E3A01002", rsp_ins); end
    checks++; if (rsp_addr !== 32'h4) begin failures++; $display("FAIL flushr_new_addr got=%08h exp=00000004", rsp_addr); end
  endtask

  task automatic test_out_of_range();
    tick();
    req_valid = 1'b1; req_addr = 32'h0000_0403;
    tick();
    req_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL oor_valid got=%0h exp=1", rsp_valid); end
    checks++; if (rsp_ins !== 32'h0) begin failures++; $display("FAIL oor_ins got=%08h exp=00000000", rsp_ins); end
    checks++; if (rsp_addr !== 32'h0000_0403) begin failures++; $display("FAIL oor_addr got=%08h exp=00000403", rsp_addr); end
  endtask

  task automatic test_load_collision();
    tick();
    req_valid = 1'b1; req_addr = 32'h4;
    load_en = 1'b1; load_addr = 8'd1; load_data = 32'h1234_5678;
    tick();
    req_valid = 1'b0; load_en = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (rsp_ins !== 32'hE3A01002) begin failures++; $display("FAIL collide_old_ins got=%08h exp=E3A01002", rsp_ins); end
    tick();
    req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (rsp_ins !== 32'h1234_5678) begin failures++; $display("FAIL collide_new_ins got=%08h exp=12345678", rsp_ins); end
  endtask

  task automatic test_reset_mid_fetch();
    tick();
    req_valid = 1'b1; req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0h exp=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0h exp=0", rsp_valid); end
    checks++; if (rsp_ins !== 32'h0) begin failures++; $display("FAIL rstmid_ins got=%08h exp=00000000", rsp_ins); end
    checks++; if (rsp_addr !== 32'h0) begin failures++; $display("FAIL rstmid_addr got=%08h exp=00000000", rsp_addr); end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after[%0d] got=%0h exp=0", i, rsp_valid); end
    end
    tick();
    req_valid = 1'b1; req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rstmid_retain_valid got=%0h exp=1", rsp_valid); end
    checks++; if (rsp_ins !== 32'hE0802001) begin failures++; $display("FAIL rstmid_retain_ins got=%08h exp=E0802001", rsp_ins); end
  endtask

  task automatic test_latency1();
    tick();
    o_load_en = 1'b1; o_load_addr = 8'd0; o_load_data = 32'hE3A00001;
    tick();
    o_load_addr = 8'd1; o_load_data = 32'hE3A01002;
    tick();
    o_load_en = 1'b0;
    o_req_valid = 1'b1; o_req_addr = 32'h0;
    @(negedge clk);
    checks++; if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL l1_valid_t0 got=%0h exp=0", o_rsp_valid); end
    tick();
    o_req_addr = 32'h4;
    @(negedge clk);
    checks++; if (o_rsp_valid !== 1'b1) begin failures++; $display("FAIL l1_valid_t1 got=%0h exp=1", o_rsp_valid); end
    checks++; if (o_rsp_ins !== 32'hE3A00001) begin failures++; $display("FAIL l1_ins_t1 got=%08h exp=E3A00001", o_rsp_ins); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL l1_busy_t1 got=%0h exp=0", o_busy); end
    tick();
    o_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (o_rsp_valid !== 1'b1) begin failures++; $display("FAIL l1_valid_t2 got=%0h exp=1", o_rsp_valid); end
    checks++; if (o_rsp_ins !== 32'hE3A01002) begin failures++; $display("FAIL l1_ins_t2 got=%08h exp=E3A01002", o_rsp_ins); end
    checks++; if (o_rsp_addr !== 32'h4) begin failures++; $display("FAIL l1_addr_t2 got=%08h exp=00000004", o_rsp_addr); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL l1_busy_t2 got=%0h exp=0", o_busy); end
    tick();
    @(negedge clk);
    checks++; if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL l1_valid_t3 got=%0h exp=0", o_rsp_valid); end
  endtask

  initial begin
    words[0] = 32'hE3A00001; words[1] = 32'hE3A01002;
    words[2] = 32'hE0802001; words[3] = 32'hEAFFFFFE;
    rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'h0; flush = 1'b0;
    load_en = 1'b0; load_addr = 8'h0; load_data = 32'h0;
    o_req_valid = 1'b0; o_req_addr = 32'h0; o_flush = 1'b0;
    o_load_en = 1'b0; o_load_addr = 8'h0; o_load_data = 32'h0;
    #2;
    test_reset();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) load_word(8'(i), words[i]);
    test_single_fetch();
    test_back_to_back();
    test_flush_wait();
    test_flush_resp();
    test_out_of_range();
    test_load_collision();
    test_reset_mid_fetch();
    test_latency1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
